// File: rtl/if_id_stage.sv
// Instruction fetch / decode stage: fetches one word over an AHB-style bus, decodes it and
// hands it to the micro-controller. Define IF_ILLEGAL_TRAP_EN to halt on illegal instructions.
module if_id_stage #(
  parameter int               COLS     = 32,
  parameter logic [COLS-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [COLS-1:0]  i_haddr,
  output logic [1:0]       i_htrans,
  input  logic             i_hready,
  input  logic [COLS-1:0]  i_hrdata,
  input  logic             done,
  input  logic             redirect_en,
  input  logic [COLS-1:0]  redirect_pc,
  output logic             id_rf_valid_inst,
  output logic [4:0]       decode_addr,
  output logic [4:0]       rd_index,
  output logic [4:0]       rs1_index,
  output logic [4:0]       rs2_index,
  output logic [COLS-1:0]  immediate,
  output logic [COLS-1:0]  pc_reg,
  output logic [COLS-1:0]  pc_plus4,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_EXEC, S_HALT
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] ADDR_ILLEGAL = 5'd31;

  state_t          r_state;
  state_t          w_next_state;
  logic [COLS-1:0] r_pc;
  logic [COLS-1:0] r_ir;
  logic [COLS-1:0] w_pc_plus4;
  logic [COLS-1:0] w_redirect_tgt;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_decode_addr;
  logic            w_illegal;
  logic [31:0]     w_imm32;
  logic            w_illegal_skip;

  // ---------------------------------------------------------------------------
  // Illegal-instruction policy
  // ---------------------------------------------------------------------------
`ifdef IF_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
  assign w_illegal_skip = 1'b0;
  assign halted         = (r_state == S_HALT);
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
  // Skipping an illegal word advances the PC exactly like a completed instruction.
  assign w_illegal_skip = (r_state == S_ISSUE) && w_illegal;
  assign halted         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Field extraction and PC arithmetic (wraps modulo 2^COLS naturally)
  // ---------------------------------------------------------------------------
  assign w_opcode       = r_ir[6:0];
  assign w_funct3       = r_ir[14:12];
  assign w_funct7       = r_ir[31:25];
  assign w_pc_plus4     = r_pc + COLS'(4);
  assign w_redirect_tgt = redirect_pc & ~COLS'(3);

  // ---------------------------------------------------------------------------
  // Micro-program entry decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_decode_addr = ADDR_ILLEGAL;
    case (w_opcode)
      OPC_LUI:    w_decode_addr = 5'd1;
      OPC_AUIPC:  w_decode_addr = 5'd2;
      OPC_JAL:    w_decode_addr = 5'd3;
      OPC_JALR:   w_decode_addr = 5'd4;
      OPC_BRANCH: w_decode_addr = 5'd5;
      OPC_LOAD:   w_decode_addr = 5'd6;
      OPC_STORE:  w_decode_addr = 5'd7;
      OPC_OPIMM: begin
        case (w_funct3)
          3'b001: begin
            if (w_funct7 == F7_BASE) w_decode_addr = 5'd9;
          end
          3'b101: begin
            if (w_funct7 == F7_BASE)     w_decode_addr = 5'd13;
            else if (w_funct7 == F7_ALT) w_decode_addr = 5'd25;
          end
          default: w_decode_addr = 5'd8 + 5'(w_funct3);
        endcase
      end
      OPC_OP: begin
        if (w_funct7 == F7_BASE)                           w_decode_addr = 5'd16 + 5'(w_funct3);
        else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) w_decode_addr = 5'd24;
        else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) w_decode_addr = 5'd25;
      end
      default: w_decode_addr = ADDR_ILLEGAL;
    endcase
  end

  assign w_illegal = (w_decode_addr == ADDR_ILLEGAL);

  // ---------------------------------------------------------------------------
  // Immediate decode by instruction format
  // ---------------------------------------------------------------------------
  always_comb begin
    w_imm32 = 32'h0;
    case (w_opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        w_imm32 = {{20{r_ir[31]}}, r_ir[31:20]};
      OPC_STORE:
        w_imm32 = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      OPC_BRANCH:
        w_imm32 = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm32 = {r_ir[31:12], 12'h000};
      OPC_JAL:
        w_imm32 = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      default:
        w_imm32 = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: if (i_hready) w_next_state = S_WAIT;
      S_WAIT:  if (i_hready) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = w_illegal ? ILLEGAL_NEXT : S_EXEC;
      S_EXEC:  if (done) w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (r_state == S_EXEC && done) begin
      r_pc <= redirect_en ? w_redirect_tgt : w_pc_plus4;
    end else if (w_illegal_skip) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: IR is reset to a NOP so the decode outputs are defined before the first fetch.
    if (!rst) begin
      r_ir <= COLS'(32'h0000_0013);
    end else if (r_state == S_WAIT && i_hready) begin
      r_ir <= i_hrdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded only from state, IR and PC
  // ---------------------------------------------------------------------------
  assign i_haddr          = r_pc;
  assign i_htrans         = (r_state == S_FETCH) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign id_rf_valid_inst = (r_state == S_ISSUE) && !w_illegal;
  assign decode_addr      = w_decode_addr;
  assign rd_index         = r_ir[11:7];
  assign rs1_index        = r_ir[19:15];
  assign rs2_index        = r_ir[24:20];
  assign immediate        = COLS'($signed(w_imm32));
  assign pc_reg           = r_pc;
  assign pc_plus4         = w_pc_plus4;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized self-checking bench for if_id_stage against an instruction-level reference model.
module tb_if_id_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] i_haddr;
  logic [1:0]  i_htrans;
  logic        i_hready;
  logic [31:0] i_hrdata;
  logic        done;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_rf_valid_inst;
  logic [4:0]  decode_addr;
  logic [4:0]  rd_index;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] immediate;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic        halted;

  int n_checks;
  int n_errors;

  logic [31:0] model_pc;
  logic [31:0] model_ir;

  if_id_stage #(.COLS(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_haddr          (i_haddr),
    .i_htrans         (i_htrans),
    .i_hready         (i_hready),
    .i_hrdata         (i_hrdata),
    .done             (done),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .id_rf_valid_inst (id_rf_valid_inst),
    .decode_addr      (decode_addr),
    .rd_index         (rd_index),
    .rs1_index        (rs1_index),
    .rs2_index        (rs2_index),
    .immediate        (immediate),
    .pc_reg           (pc_reg),
    .pc_plus4         (pc_plus4),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Micro-program entry table, written from the opcode list.
  function automatic logic [4:0] ref_entry(input logic [31:0] ins);
    logic [31:0] op, f3, f7;
    op = ins & 32'h7f;
    f3 = (ins >> 12) & 32'h7;
    f7 = ins >> 25;
    case (op)
      32'h37: return 5'd1;
      32'h17: return 5'd2;
      32'h6f: return 5'd3;
      32'h67: return 5'd4;
      32'h63: return 5'd5;
      32'h03: return 5'd6;
      32'h23: return 5'd7;
      32'h13: begin
        if (f3 == 1) return (f7 == 0) ? 5'd9 : 5'd31;
        if (f3 == 5) return (f7 == 0) ? 5'd13 : ((f7 == 32) ? 5'd25 : 5'd31);
        return 5'(8 + f3);
      end
      32'h33: begin
        if (f7 == 0)             return 5'(16 + f3);
        if (f7 == 32 && f3 == 0) return 5'd24;
        if (f7 == 32 && f3 == 5) return 5'd25;
        return 5'd31;
      end
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] op;
    logic [31:0] sgn;
    op  = ins & 32'h7f;
    sgn = ins >> 31;
    case (op)
      32'h03, 32'h13, 32'h67: return 32'($signed(ins) >>> 20);
      32'h23: return (32'($signed(ins) >>> 20) & ~32'h1f) | ((ins >> 7) & 32'h1f);
      32'h63: return ((sgn != 0) ? 32'hFFFF_F000 : 32'h0) | (((ins >> 7) & 32'h1) << 11)
                     | (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
      32'h37, 32'h17: return ins & 32'hFFFF_F000;
      32'h6f: return ((sgn != 0) ? 32'hFFF0_0000 : 32'h0) | (ins & 32'h000F_F000)
                     | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    logic [6:0]  op;
    int          k;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    if ($urandom_range(0, 7) == 0) return w;
    op = ops[$urandom_range(0, 8)];
    w  = (w & ~32'h7f) | 32'(op);
    if (op == 7'h13 || op == 7'h33) begin
      k = $urandom_range(0, 5);
      if (k < 3)       w = w & 32'h01FF_FFFF;
      else if (k < 5)  w = (w & 32'h01FF_FFFF) | 32'h4000_0000;
    end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_htrans", 32'(i_htrans), 32'h0);
    check("rst_pc", pc_reg, RESET_PC);
    check("rst_haddr", i_haddr, RESET_PC);
    check("rst_strobe", 32'(id_rf_valid_inst), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_decode", 32'(decode_addr), 32'd8);
    step();
    rst = 1'b1;
    #1;
    check("idle_htrans", 32'(i_htrans), 32'h0);
    step();
    model_pc = RESET_PC;
    model_ir = NOP;
    check("first_fetch_htrans", 32'(i_htrans), 32'h2);
    check("first_fetch_addr", i_haddr, RESET_PC);
  endtask

  // One full fetch/issue/execute transaction. Entered and left with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw, input int ex,
                           input logic redir, input logic [31:0] rpc);
    logic [4:0] exp_addr;
    for (int i = 0; i < fw; i++) begin
      i_hready = 1'b0; done = 1'($urandom); redirect_en = 1'b1; redirect_pc = $urandom;
      step();
      check("fetch_hold_htrans", 32'(i_htrans), 32'h2);
      check("fetch_hold_addr", i_haddr, model_pc);
    end
    i_hready = 1'b1; done = 1'($urandom); redirect_en = 1'b1; redirect_pc = $urandom;
    step();
    check("wait_htrans", 32'(i_htrans), 32'h0);
    check("wait_pc", pc_reg, model_pc);
    for (int i = 0; i < dw; i++) begin
      i_hready = 1'b0; i_hrdata = $urandom; done = 1'($urandom);
      step();
      check("wait_strobe", 32'(id_rf_valid_inst), 32'h0);
      check("wait_ir_held", 32'(decode_addr), 32'(ref_entry(model_ir)));
      check("wait_htrans_hold", 32'(i_htrans), 32'h0);
    end
    i_hready = 1'b1; i_hrdata = ins; done = 1'b0;
    step();
    model_ir = ins;
    i_hready = 1'($urandom); i_hrdata = $urandom;
    exp_addr = ref_entry(ins);
    check("decode_addr", 32'(decode_addr), 32'(exp_addr));
    check("rd", 32'(rd_index), (ins >> 7) & 32'h1f);
    check("rs1", 32'(rs1_index), (ins >> 15) & 32'h1f);
    check("rs2", 32'(rs2_index), (ins >> 20) & 32'h1f);
    check("imm", immediate, ref_imm(ins));
    check("pc_plus4", pc_plus4, model_pc + 32'd4);
    if (exp_addr != 5'd31) begin
      check("issue_strobe", 32'(id_rf_valid_inst), 32'h1);
      done = 1'b1; redirect_en = 1'b1; redirect_pc = $urandom;
      step();
      check("exec_strobe", 32'(id_rf_valid_inst), 32'h0);
      check("exec_pc", pc_reg, model_pc);
      for (int i = 0; i < ex; i++) begin
        done = 1'b0; redirect_en = 1'($urandom); i_hrdata = $urandom;
        step();
        check("exec_hold_pc", pc_reg, model_pc);
        check("exec_hold_decode", 32'(decode_addr), 32'(exp_addr));
        check("exec_hold_imm", immediate, ref_imm(ins));
        check("exec_hold_htrans", 32'(i_htrans), 32'h0);
      end
      done = 1'b1; redirect_en = redir; redirect_pc = rpc;
      step();
      done = 1'b0; redirect_en = 1'b0;
      model_pc = redir ? (rpc & ~32'h3) : model_pc + 32'd4;
    end else begin
      check("illegal_strobe", 32'(id_rf_valid_inst), 32'h0);
      done = 1'b0;
`ifdef IF_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
        done = 1'($urandom);
        step();
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_strobe", 32'(id_rf_valid_inst), 32'h0);
        check("halt_htrans", 32'(i_htrans), 32'h0);
      end
      done = 1'b0;
      do_reset();
`else
      step();
      check("illegal_halted", 32'(halted), 32'h0);
      model_pc = model_pc + 32'd4;
`endif
    end
    check("next_fetch_htrans", 32'(i_htrans), 32'h2);
    check("next_fetch_addr", i_haddr, model_pc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; i_hready = 1'b0; i_hrdata = 32'h0;
    done = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    model_pc = RESET_PC;
    model_ir = NOP;
    #3;
    do_reset();

    // ADDI x1, x0, 5 with zero wait states: strobe lands in the third cycle after FETCH entry.
    run_instr(32'h0050_0093, 0, 0, 2, 1'b0, 32'h0);
    check("addi_decode", 32'(decode_addr), 32'd8);
    check("addi_rd", 32'(rd_index), 32'd1);
    check("addi_imm", immediate, 32'd5);

    // Sequential and redirected next-PC.
    run_instr(NOP, 0, 0, 1, 1'b1, 32'h0000_0010);
    run_instr(NOP, 0, 0, 0, 1'b0, 32'h0);
    check("seq_pc", i_haddr, 32'h0000_0014);
    run_instr(NOP, 1, 0, 1, 1'b1, 32'h0000_0103);
    check("redir_pc", i_haddr, 32'h0000_0100);

    // Data-phase wait states, SUB decode.
    run_instr(32'h4020_8033, 1, 4, 1, 1'b0, 32'h0);
    check("sub_decode", 32'(decode_addr), 32'd24);

    // PC wrap at the top of the address space.
    run_instr(NOP, 0, 0, 0, 1'b1, 32'hFFFF_FFFE);
    check("top_pc", i_haddr, 32'hFFFF_FFFC);
    run_instr(NOP, 0, 0, 0, 1'b0, 32'h0);
    check("wrap_pc", i_haddr, 32'h0000_0000);

    // Illegal word.
    run_instr(NOP, 0, 0, 0, 1'b1, 32'h0000_0040);
    run_instr(32'hFFFF_FFFF, 0, 1, 0, 1'b0, 32'h0);
    check("illegal_decode", 32'(decode_addr), 32'd31);

    // Done pulse while in FETCH leaves the PC alone.
    run_instr(NOP, 0, 0, 0, 1'b1, 32'h0000_0080);
    done = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h0000_0200; i_hready = 1'b0;
    step();
    done = 1'b0; redirect_en = 1'b0;
    check("done_in_fetch_pc", pc_reg, 32'h0000_0080);

    // Asynchronous reset in the middle of WAIT, then in the middle of FETCH.
    i_hready = 1'b1;
    step();
    i_hready = 1'b0;
    check("pre_rst_wait_htrans", 32'(i_htrans), 32'h0);
    do_reset();
    run_instr(NOP, 0, 0, 0, 1'b1, 32'h0000_0300);
    i_hready = 1'b0;
    check("pre_rst_fetch_htrans", 32'(i_htrans), 32'h2);
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
